// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked multi-cycle ALU: logic, add/sub, iterative shifts, shift-add multiply, ZNCV flags
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;

    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
    localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_op;
    logic [WIDTH-1:0]       r_work;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]     r_acc;
    logic [SHW:0]           r_cnt;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_result;
    logic                   r_flag_z;
    logic                   r_flag_n;
    logic                   r_flag_c;
    logic                   r_flag_v;

    logic [SHW-1:0]         w_shamt;
    logic                   w_sub;
    logic [WIDTH-1:0]       w_b_eff;
    logic [WIDTH:0]         w_sum;
    logic                   w_sum_v;
    logic [WIDTH-1:0]       w_sc_res;
    logic                   w_sc_c;
    logic                   w_sc_v;
    logic                   w_sc_def;
    logic                   w_is_shift;

    logic [WIDTH-1:0]       w_shift_next;
    logic                   w_shift_out;
    logic [2*WIDTH-1:0]     w_acc_next;
    logic [WIDTH-1:0]       w_fin_res;
    logic                   w_fin_c;
    logic                   w_fin_v;

    assign w_shamt    = b[SHW-1:0];
    assign w_is_shift = (op == OP_SLL) || (op == OP_SRL);

    // SUB shares the adder as a + ~b + 1, so carry-out means "no borrow".
    always_comb begin
        w_sub   = (op == OP_SUB);
        w_b_eff = w_sub ? ~b : b;
        w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
        w_sum_v = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    end

    always_comb begin
        w_sc_res = '0;
        w_sc_c   = 1'b0;
        w_sc_v   = 1'b0;
        w_sc_def = 1'b1;
        case (op)
            OP_AND: w_sc_res = a & b;
            OP_OR:  w_sc_res = a | b;
            OP_XOR: w_sc_res = a ^ b;
            OP_ADD, OP_SUB: begin
                w_sc_res = w_sum[WIDTH-1:0];
                w_sc_c   = w_sum[WIDTH];
                w_sc_v   = w_sum_v;
            end
            OP_SLL, OP_SRL, OP_MUL: w_sc_res = a;
            default: w_sc_def = 1'b0;
        endcase
    end

    always_comb begin
        if (r_op == OP_SLL) begin
            w_shift_next = {r_work[WIDTH-2:0], 1'b0};
            w_shift_out  = r_work[WIDTH-1];
        end else begin
            w_shift_next = {1'b0, r_work[WIDTH-1:1]};
            w_shift_out  = r_work[0];
        end
    end

    // Multiplier bits are consumed LSB first out of r_work while the multiplicand walks left.
    assign w_acc_next = r_work[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        if (r_op == OP_MUL) begin
            w_fin_res = w_acc_next[WIDTH-1:0];
            w_fin_c   = |w_acc_next[2*WIDTH-1:WIDTH];
            w_fin_v   = |w_acc_next[2*WIDTH-1:WIDTH];
        end else begin
            w_fin_res = w_shift_next;
            w_fin_c   = w_shift_out;
            w_fin_v   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_work      <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flag_z    <= 1'b0;
            r_flag_n    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op       <= op;
                        r_in_ready <= 1'b0;
                        if (op == OP_MUL) begin
                            r_work  <= b;
                            r_mcand <= {{WIDTH{1'b0}}, a};
                            r_acc   <= '0;
                            r_cnt   <= CNT_MUL;
                            r_state <= S_BUSY;
                        end else if (w_is_shift && (w_shamt != '0)) begin
                            r_work  <= a;
                            r_cnt   <= {1'b0, w_shamt};
                            r_state <= S_BUSY;
                        end else begin
                            r_result    <= w_sc_res;
                            r_flag_z    <= w_sc_def && (w_sc_res == '0);
                            r_flag_n    <= w_sc_def && w_sc_res[WIDTH-1];
                            r_flag_c    <= w_sc_c;
                            r_flag_v    <= w_sc_v;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_op == OP_MUL) begin
                        r_acc   <= w_acc_next;
                        r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
                        r_work  <= {1'b0, r_work[WIDTH-1:1]};
                    end else begin
                        r_work <= w_shift_next;
                    end
                    if (r_cnt == CNT_ONE) begin
                        r_result    <= w_fin_res;
                        r_flag_z    <= (w_fin_res == '0);
                        r_flag_n    <= w_fin_res[WIDTH-1];
                        r_flag_c    <= w_fin_c;
                        r_flag_v    <= w_fin_v;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_z    = r_flag_z;
    assign flag_n    = r_flag_n;
    assign flag_c    = r_flag_c;
    assign flag_v    = r_flag_v;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu with a behavioural reference model
module tb_seq_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
    logic        flag_v;
    logic [3:0]  flags;

    int errors;
    int checks;

    assign flags = {flag_z, flag_n, flag_c, flag_v};

    seq_alu #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arithmetic on wide integers; flags packed {z,n,c,v}.
    function automatic void model(input logic [3:0] mop, input logic [15:0] ma, input logic [15:0] mb,
                                  output logic [15:0] r, output logic [3:0] f, output int lat);
        logic [31:0] p;
        logic [15:0] t;
        int          si;
        int          sh;
        logic        c;
        logic        v;
        logic        def;
        c   = 1'b0;
        v   = 1'b0;
        def = 1'b1;
        lat = 1;
        sh  = int'(mb[3:0]);
        case (mop)
            4'd0: r = ma & mb;
            4'd3: r = ma | mb;
            4'd4: r = ma ^ mb;
            4'd1: begin
                p  = 32'(ma) + 32'(mb);
                r  = p[15:0];
                c  = p[16];
                si = int'($signed(ma)) + int'($signed(mb));
                v  = (si > 32767) || (si < -32768);
            end
            4'd2: begin
                r  = ma - mb;
                c  = (ma >= mb);
                si = int'($signed(ma)) - int'($signed(mb));
                v  = (si > 32767) || (si < -32768);
            end
            4'd5: begin
                r   = ma << sh;
                t   = ma >> (16 - sh);
                c   = (sh == 0) ? 1'b0 : t[0];
                lat = sh + 1;
            end
            4'd6: begin
                r   = ma >> sh;
                t   = ma >> ((sh == 0) ? 0 : sh - 1);
                c   = (sh == 0) ? 1'b0 : t[0];
                lat = sh + 1;
            end
            4'd7: begin
                p   = 32'(ma) * 32'(mb);
                r   = p[15:0];
                c   = (p[31:16] != 16'd0);
                v   = c;
                lat = 17;
            end
            default: begin
                r   = 16'd0;
                def = 1'b0;
            end
        endcase
        f = {def && (r == 16'd0), def && r[15], c, v};
    endfunction

    // Drives one accept and returns the accept-to-out_valid latency (-1 on timeout); ends at a negedge.
    task automatic start_op(input logic [3:0] o, input logic [15:0] aa, input logic [15:0] bb, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        op = o;
        a = aa;
        b = bb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom);
        a = 16'($urandom);
        b = 16'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        if (!out_valid) lat = -1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
        checks++;
        if (result !== 16'h0000 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_out result=%h flags=%b exp 0000/0000", result, flags);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int lat;
        int seen;
        start_op(4'd1, 16'h0001, 16'h0001, lat);
        consume();
        in_valid = 1'b1;
        op = 4'd7;
        a = 16'h0003;
        b = 16'h0005;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy out_valid=%b in_ready=%b exp 0/0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0000 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL abort_reset out_valid=%b in_ready=%b result=%h flags=%b exp 0/1/0000/0000",
                     out_valid, in_ready, result, flags);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_spurious out_valid_cycles=%0d exp 0", seen);
        end
    endtask

    // Directed table: op, a, b, expected result, expected flags, expected latency.
    task automatic run_directed(input string name, input logic [3:0] o, input logic [15:0] aa, input logic [15:0] bb,
                                input logic [15:0] er, input logic [3:0] ef, input int el);
        int lat;
        start_op(o, aa, bb, lat);
        checks++;
        if (lat != el) begin
            errors++;
            $display("FAIL %s latency got=%0d exp=%0d", name, lat, el);
        end
        checks++;
        if (result !== er || flags !== ef) begin
            errors++;
            $display("FAIL %s result=%h flags=%b exp %h/%b", name, result, flags, er, ef);
        end
        consume();
    endtask

    task automatic test_addsub();
        run_directed("add_ovf", 4'd1, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1);
        run_directed("sub_zero", 4'd2, 16'h0005, 16'h0005, 16'h0000, 4'b1010, 1);
        run_directed("sub_borrow", 4'd2, 16'h0000, 16'h0001, 16'hFFFF, 4'b0100, 1);
    endtask

    task automatic test_shifts();
        run_directed("sll_15", 4'd5, 16'h0001, 16'h000F, 16'h8000, 4'b0100, 16);
        run_directed("srl_1", 4'd6, 16'h0003, 16'h0001, 16'h0001, 4'b0010, 2);
        run_directed("sll_0", 4'd5, 16'h1234, 16'h0010, 16'h1234, 4'b0000, 1);
    endtask

    task automatic test_mul();
        run_directed("mul_small", 4'd7, 16'h0123, 16'h0010, 16'h1230, 4'b0000, 17);
        run_directed("mul_ovf", 4'd7, 16'h0100, 16'h0100, 16'h0000, 4'b1011, 17);
    endtask

    task automatic test_undef();
        run_directed("undef_c", 4'hC, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0000, 1);
    endtask

    task automatic test_backpressure();
        int lat;
        int seen;
        start_op(4'd0, 16'hF0F0, 16'h0FF0, lat);
        checks++;
        if (lat != 1 || result !== 16'h00F0 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL bp_first lat=%0d result=%h flags=%b exp 1/00f0/0000", lat, result, flags);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                in_valid = 1'b1;
                op = 4'd1;
                a = 16'h0001;
                b = 16'h0001;
            end
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h00F0 || flags !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold[%0d] out_valid=%b in_ready=%b result=%h flags=%b exp 1/0/00f0/0000",
                         i, out_valid, in_ready, result, flags);
            end
        end
        consume();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0 || result !== 16'h00F0) begin
            errors++;
            $display("FAIL bp_ignored out_valid_cycles=%0d result=%h exp 0/00f0", seen, result);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  o;
        logic [15:0] aa;
        logic [15:0] bb;
        logic [15:0] er;
        logic [3:0]  ef;
        int          el;
        int          lat;
        int          stall;
        for (int n = 0; n < 60; n++) begin
            o = 4'($urandom_range(0, 15));
            aa = 16'($urandom);
            bb = 16'($urandom);
            if (n % 7 == 0) aa = 16'h8000;
            if (n % 11 == 0) bb = 16'hFFFF;
            model(o, aa, bb, er, ef, el);
            start_op(o, aa, bb, lat);
            checks++;
            if (lat != el) begin
                errors++;
                $display("FAIL rnd[%0d] op=%h latency got=%0d exp=%0d", n, o, lat, el);
            end
            stall = $urandom_range(0, 3);
            repeat (stall) @(negedge clk);
            checks++;
            if (result !== er || flags !== ef || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rnd[%0d] op=%h a=%h b=%h result=%h flags=%b ov=%b exp %h/%b/1",
                         n, o, aa, bb, result, flags, out_valid, er, ef);
            end
            consume();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rnd[%0d] return_idle in_ready=%b out_valid=%b exp 1/0", n, in_ready, out_valid);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        test_reset();
        test_abort();
        test_addsub();
        test_shifts();
        test_mul();
        test_undef();
        test_backpressure();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
